// File: rtl/monster_mode_ctrl_if.sv
// monster_mode_ctrl_if
//   Groups the event inputs and mode outputs exchanged between the game
//   logic layer (master) and the monster mode controller (slave).
//   Inputs to the controller:
//     startOfFrame  one-cycle pulse per video frame
//     powerPellet   one-cycle pulse: pacman ate a power pellet
//     pause         level: freeze timers and ignore collisions
//     collision[2:0] per-monster collision level (0 tracker, 1 randomS, 2 randomD)
//   Outputs from the controller:
//     shiftImage, frightened, monsterVisible[2:0], respawnReq[2:0],
//     pacmanHit, scorePulse, scoreValue[11:0]
interface monster_mode_ctrl_if;
  logic        startOfFrame;
  logic        powerPellet;
  logic        pause;
  logic [2:0]  collision;
  logic        shiftImage;
  logic        frightened;
  logic [2:0]  monsterVisible;
  logic [2:0]  respawnReq;
  logic        pacmanHit;
  logic        scorePulse;
  logic [11:0] scoreValue;

  modport master (
    output startOfFrame, powerPellet, pause, collision,
    input  shiftImage, frightened, monsterVisible, respawnReq,
           pacmanHit, scorePulse, scoreValue
  );

  modport slave (
    input  startOfFrame, powerPellet, pause, collision,
    output shiftImage, frightened, monsterVisible, respawnReq,
           pacmanHit, scorePulse, scoreValue
  );
endinterface

// File: rtl/monster_mode_ctrl.sv
// monster_mode_ctrl
//   Global mode sequencer for the three monsters. Runs the
//   NORMAL -> FRIGHT -> WARN (blinking) -> NORMAL cycle triggered by power
//   pellets, turns collisions into pacman-hit or monster-eaten events with a
//   chained score (200/400/800/1600), and hides eaten monsters until their
//   respawn timer expires.
//   Ports:
//     clk     system clock
//     resetN  asynchronous reset, active-low
//     bus     monster_mode_ctrl_if.slave (events in, mode/visibility/score out)
//   All outputs are registered.
module monster_mode_ctrl #(
  parameter int FRIGHT_FRAMES  = 360,
  parameter int WARN_FRAMES    = 120,
  parameter int BLINK_PERIOD   = 15,
  parameter int RESPAWN_FRAMES = 180,
  parameter int BASE_SCORE     = 200
) (
  input  logic               clk,
  input  logic               resetN,
  monster_mode_ctrl_if.slave bus
);

  localparam logic [9:0]  FRIGHT_LOAD  = 10'(FRIGHT_FRAMES);
  localparam logic [9:0]  WARN_ENTRY   = 10'(WARN_FRAMES + 1);
  localparam logic [9:0]  BLINK_LAST   = 10'(BLINK_PERIOD - 1);
  localparam logic [9:0]  RESPAWN_LOAD = 10'(RESPAWN_FRAMES);
  localparam logic [11:0] BASE_VALUE   = 12'(BASE_SCORE);

  typedef enum logic [1:0] {NORMAL, FRIGHT, WARN} state_t;

  state_t      state_reg, state_next;
  logic [9:0]  mode_cnt_reg, mode_cnt_next;
  logic [9:0]  blink_cnt_reg, blink_cnt_next;
  logic        shift_reg, shift_next;
  logic        fright_reg, fright_next;
  logic [1:0]  chain_reg, chain_next;
  logic        hit_reg, hit_next;
  logic        score_pulse_reg, score_pulse_next;
  logic [11:0] score_value_reg, score_value_next;
  logic [2:0]  visible_reg;
  logic [2:0]  respawn_req_reg;

  logic        tick;
  logic [2:0]  eff_coll;
  logic [2:0]  eat_sel;

  assign tick     = bus.startOfFrame & ~bus.pause;
  assign eff_coll = bus.pause ? 3'b000 : (bus.collision & visible_reg);
  // Isolate the lowest set bit: tracker beats randomS beats randomD.
  assign eat_sel  = (state_reg != NORMAL) ? (eff_coll & (~eff_coll + 3'd1)) : 3'b000;

  // Per-monster visibility and respawn timer. A hidden monster always has a
  // non-zero counter, so "counter != 0" doubles as the hidden flag.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_monster
      logic [9:0] cnt_reg, cnt_next;
      logic       vis_reg, vis_next;
      logic       req_reg, req_next;

      always_comb begin
        cnt_next = cnt_reg;
        vis_next = vis_reg;
        req_next = 1'b0;
        if (eat_sel[gi]) begin
          cnt_next = RESPAWN_LOAD;
          vis_next = 1'b0;
        end else if (tick && cnt_reg != 10'd0) begin
          cnt_next = cnt_reg - 10'd1;
          if (cnt_reg == 10'd1) begin
            vis_next = 1'b1;
            req_next = 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          cnt_reg <= 10'd0;
          vis_reg <= 1'b1;
          req_reg <= 1'b0;
        end else begin
          cnt_reg <= cnt_next;
          vis_reg <= vis_next;
          req_reg <= req_next;
        end
      end

      assign visible_reg[gi]     = vis_reg;
      assign respawn_req_reg[gi] = req_reg;
    end
  endgenerate

  // Mode FSM, collision results and score chain.
  always_comb begin
    state_next       = state_reg;
    mode_cnt_next    = mode_cnt_reg;
    blink_cnt_next   = blink_cnt_reg;
    shift_next       = shift_reg;
    chain_next       = chain_reg;
    hit_next         = 1'b0;
    score_pulse_next = 1'b0;
    score_value_next = score_value_reg;

    // Collisions are judged against the state before this cycle's update.
    if (state_reg == NORMAL) begin
      if (eff_coll != 3'b000) hit_next = 1'b1;
    end else if (eff_coll != 3'b000) begin
      score_pulse_next = 1'b1;
      score_value_next = BASE_VALUE << chain_reg;
      if (chain_reg != 2'd3) chain_next = chain_reg + 2'd1;
    end

    // Mode update comes second so a pellet or fright expiry in the same
    // cycle as an eat still restarts the chain.
    if (bus.powerPellet) begin
      state_next    = FRIGHT;
      mode_cnt_next = FRIGHT_LOAD;
      shift_next    = 1'b1;
      chain_next    = 2'd0;
    end else begin
      case (state_reg)
        FRIGHT: begin
          if (tick) begin
            mode_cnt_next = mode_cnt_reg - 10'd1;
            if (mode_cnt_reg == WARN_ENTRY) begin
              shift_next = 1'b0;
              if (WARN_FRAMES == 0) begin
                // No blinking tail: fright ends straight into NORMAL.
                state_next = NORMAL;
                chain_next = 2'd0;
              end else begin
                state_next     = WARN;
                blink_cnt_next = 10'd0;
              end
            end
          end
        end
        WARN: begin
          if (tick) begin
            mode_cnt_next = mode_cnt_reg - 10'd1;
            if (mode_cnt_reg == 10'd1) begin
              state_next = NORMAL;
              shift_next = 1'b0;
              chain_next = 2'd0;
            end else if (blink_cnt_reg == BLINK_LAST) begin
              blink_cnt_next = 10'd0;
              shift_next     = ~shift_reg;
            end else begin
              blink_cnt_next = blink_cnt_reg + 10'd1;
            end
          end
        end
        default: state_next = NORMAL;
      endcase
    end

    fright_next = (state_next != NORMAL);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg       <= NORMAL;
      mode_cnt_reg    <= 10'd0;
      blink_cnt_reg   <= 10'd0;
      shift_reg       <= 1'b0;
      fright_reg      <= 1'b0;
      chain_reg       <= 2'd0;
      hit_reg         <= 1'b0;
      score_pulse_reg <= 1'b0;
      score_value_reg <= 12'd0;
    end else begin
      state_reg       <= state_next;
      mode_cnt_reg    <= mode_cnt_next;
      blink_cnt_reg   <= blink_cnt_next;
      shift_reg       <= shift_next;
      fright_reg      <= fright_next;
      chain_reg       <= chain_next;
      hit_reg         <= hit_next;
      score_pulse_reg <= score_pulse_next;
      score_value_reg <= score_value_next;
    end
  end

  assign bus.shiftImage     = shift_reg;
  assign bus.frightened     = fright_reg;
  assign bus.monsterVisible = visible_reg;
  assign bus.respawnReq     = respawn_req_reg;
  assign bus.pacmanHit      = hit_reg;
  assign bus.scorePulse     = score_pulse_reg;
  assign bus.scoreValue     = score_value_reg;

endmodule

// File: tb/tb_monster_mode_ctrl.sv
// tb_monster_mode_ctrl
//   Directed scenarios plus a randomized run, checked every cycle against a
//   frame-count model: fright is "frames remaining", blinking phase is derived
//   arithmetically from frames elapsed in the tail, respawn is "frames hidden
//   remaining" per monster, and the score is BASE * 2^min(eats,3).
module tb_monster_mode_ctrl;
  localparam int FRIGHT  = 360;
  localparam int WARN    = 120;
  localparam int BLINK   = 15;
  localparam int RESPAWN = 180;
  localparam int BASE    = 200;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  monster_mode_ctrl_if bus();

  monster_mode_ctrl #(
    .FRIGHT_FRAMES(FRIGHT), .WARN_FRAMES(WARN), .BLINK_PERIOD(BLINK),
    .RESPAWN_FRAMES(RESPAWN), .BASE_SCORE(BASE)
  ) dut (
    .clk(clk), .resetN(resetN), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // ---------------- behavioural model ----------------
  int       rem;        // fright frames remaining (0 = normal)
  int       eaten;      // monsters eaten since chain restart
  int       hid [3];    // frames until respawn (0 = visible)
  bit [2:0] m_vis, m_req;
  bit       m_hit, m_sp;
  int       m_sv;

  function automatic void model_reset();
    rem = 0; eaten = 0;
    for (int i = 0; i < 3; i++) hid[i] = 0;
    m_vis = 3'b111; m_req = 3'b000; m_hit = 0; m_sp = 0; m_sv = 0;
  endfunction

  function automatic bit exp_shift();
    if (rem == 0) return 1'b0;
    if (rem > WARN) return 1'b1;
    return (((WARN - rem) / BLINK) % 2) == 1;
  endfunction

  function automatic void model_step(bit sof, bit pp, bit pau, bit [2:0] col);
    bit       tick;
    bit [2:0] eff;
    int       idx;
    int       lvl;
    tick = sof && !pau;
    eff  = pau ? 3'b000 : (col & m_vis);
    m_req = 3'b000; m_hit = 0; m_sp = 0;
    for (int i = 0; i < 3; i++) begin
      if (tick && hid[i] > 0) begin
        hid[i]--;
        if (hid[i] == 0) begin m_vis[i] = 1'b1; m_req[i] = 1'b1; end
      end
    end
    if (eff != 3'b000) begin
      if (rem == 0) m_hit = 1;
      else begin
        idx = eff[0] ? 0 : (eff[1] ? 1 : 2);
        lvl = (eaten > 3) ? 3 : eaten;
        m_sp = 1;
        m_sv = BASE * (1 << lvl);
        eaten++;
        hid[idx] = RESPAWN;
        m_vis[idx] = 1'b0;
      end
    end
    if (pp) begin
      rem = FRIGHT; eaten = 0;
    end else if (rem > 0 && tick) begin
      rem--;
      if (rem == 0) eaten = 0;
    end
  endfunction

  // ---------------- checking ----------------
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_outputs();
    chk("shiftImage",     int'(bus.shiftImage),     int'(exp_shift()));
    chk("frightened",     int'(bus.frightened),     int'(rem > 0));
    chk("monsterVisible", int'(bus.monsterVisible), int'(m_vis));
    chk("respawnReq",     int'(bus.respawnReq),     int'(m_req));
    chk("pacmanHit",      int'(bus.pacmanHit),      int'(m_hit));
    chk("scorePulse",     int'(bus.scorePulse),     int'(m_sp));
    chk("scoreValue",     int'(bus.scoreValue),     m_sv);
  endtask

  task automatic drive(bit sof, bit pp, bit pau, bit [2:0] col);
    bus.startOfFrame = sof;
    bus.powerPellet  = pp;
    bus.pause        = pau;
    bus.collision    = col;
  endtask

  // One clock: the model consumes what the DUT sampled, outputs are checked
  // on the falling edge.
  task automatic step();
    @(posedge clk);
    model_step(bus.startOfFrame, bus.powerPellet, bus.pause, bus.collision);
    cyc++;
    @(negedge clk);
    check_outputs();
    if (m_sp)  $display("cycle %0d: monster eaten, score %0d", cyc, m_sv);
    if (m_hit) $display("cycle %0d: pacman hit", cyc);
    if (m_req != 3'b000) $display("cycle %0d: respawn %b", cyc, m_req);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) begin
      drive(1, 0, 0, 3'b000);
      step();
    end
  endtask

  task automatic check_reset_literals();
    chk("rst_shiftImage", int'(bus.shiftImage),     0);
    chk("rst_frightened", int'(bus.frightened),     0);
    chk("rst_visible",    int'(bus.monsterVisible), 7);
    chk("rst_respawnReq", int'(bus.respawnReq),     0);
    chk("rst_pacmanHit",  int'(bus.pacmanHit),      0);
    chk("rst_scorePulse", int'(bus.scorePulse),     0);
    chk("rst_scoreValue", int'(bus.scoreValue),     0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 3'b000);
    resetN = 1'b0;
    #1;
    model_reset();
    check_reset_literals();
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 0, 3'b000);
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Idle frames leave everything unchanged.
    ticks(10);
    chk("idle_visible", int'(bus.monsterVisible), 7);
    chk("idle_shift",   int'(bus.shiftImage),     0);

    // Full fright cycle with blinking tail.
    drive(0, 1, 0, 3'b000); step();
    chk("pp_shift", int'(bus.shiftImage), 1);
    for (int t = 1; t <= FRIGHT; t++) begin
      drive(1, 0, 0, 3'b000); step();
      if (t == 239) chk("t239_shift", int'(bus.shiftImage), 1);
      if (t == 240) begin
        chk("t240_shift", int'(bus.shiftImage), 0);
        chk("t240_fright", int'(bus.frightened), 1);
      end
      if (t == 254) chk("t254_shift", int'(bus.shiftImage), 0);
      if (t == 255) chk("t255_shift", int'(bus.shiftImage), 1);
      if (t == 270) chk("t270_shift", int'(bus.shiftImage), 0);
      if (t == 359) chk("t359_fright", int'(bus.frightened), 1);
      if (t == 360) chk("t360_fright", int'(bus.frightened), 0);
    end

    // Chain of eats, saturating at 1600.
    do_reset();
    drive(0, 1, 0, 3'b000); step();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 3'b111); step();
      chk("chain_pulse", int'(bus.scorePulse), 1);
      chk("chain_value", int'(bus.scoreValue), 200 << k);
    end
    chk("chain_allhidden", int'(bus.monsterVisible), 0);
    for (int t = 1; t <= RESPAWN; t++) begin
      drive(1, 0, 0, 3'b000); step();
      if (t == RESPAWN) chk("chain_respawn", int'(bus.respawnReq), 7);
    end
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 3'b111); step();
      chk("chain_sat", int'(bus.scoreValue), 1600);
    end

    // Respawn timing stretched by 50 paused frames.
    do_reset();
    drive(0, 1, 0, 3'b000); step();
    drive(0, 0, 0, 3'b001); step();
    chk("eat0_value", int'(bus.scoreValue), 200);
    chk("eat0_vis",   int'(bus.monsterVisible), 6);
    for (int t = 1; t <= RESPAWN + 50; t++) begin
      drive(1, 0, (t >= 50 && t < 100), 3'b000); step();
      if (t == RESPAWN)          chk("paused_no_respawn", int'(bus.respawnReq), 0);
      if (t == RESPAWN + 49)     chk("pre_respawn", int'(bus.respawnReq), 0);
      if (t == RESPAWN + 50) begin
        chk("respawn0", int'(bus.respawnReq), 1);
        chk("respawn0_vis", int'(bus.monsterVisible), 7);
      end
    end

    // Pacman hit in NORMAL, ignored for a hidden monster.
    do_reset();
    drive(0, 0, 0, 3'b010); step();
    chk("hit_pulse", int'(bus.pacmanHit), 1);
    chk("hit_vis",   int'(bus.monsterVisible), 7);
    drive(0, 0, 0, 3'b000); step();
    chk("hit_once",  int'(bus.pacmanHit), 0);
    drive(0, 1, 0, 3'b000); step();
    ticks(200);
    drive(0, 0, 0, 3'b010); step();
    chk("eat1_vis", int'(bus.monsterVisible), 5);
    ticks(160);
    chk("back_normal", int'(bus.frightened), 0);
    drive(0, 0, 0, 3'b010); step();
    chk("hidden_nohit", int'(bus.pacmanHit), 0);
    drive(0, 0, 0, 3'b110); step();
    chk("visible2_hit", int'(bus.pacmanHit), 1);

    // Collision together with a pellet in NORMAL.
    drive(0, 1, 0, 3'b100); step();
    chk("pp_hit", int'(bus.pacmanHit), 1);
    chk("pp_hit_fright", int'(bus.frightened), 1);

    // Pellet re-armed late in fright restarts timer and chain.
    do_reset();
    drive(0, 1, 0, 3'b000); step();
    drive(0, 0, 0, 3'b001); step();
    ticks(300);
    drive(0, 1, 0, 3'b000); step();
    chk("rearm_shift", int'(bus.shiftImage), 1);
    drive(0, 0, 0, 3'b010); step();
    chk("rearm_chain", int'(bus.scoreValue), 200);
    for (int t = 1; t <= FRIGHT; t++) begin
      drive(1, 0, 0, 3'b000); step();
      if (t == FRIGHT - 1) chk("rearm_359", int'(bus.frightened), 1);
      if (t == FRIGHT)     chk("rearm_360", int'(bus.frightened), 0);
    end

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      drive($urandom_range(0, 1) == 1,
            $urandom_range(0, 299) == 0,
            $urandom_range(0, 7) == 0,
            ($urandom_range(0, 11) == 0) ? 3'($urandom_range(1, 7)) : 3'b000);
      step();
    end

    // Reset asserted in the middle of WARN.
    do_reset();
    drive(0, 1, 0, 3'b000); step();
    ticks(250);
    drive(0, 0, 0, 3'b001); step();
    chk("warn_fright", int'(bus.frightened), 1);
    do_reset();
    ticks(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
